column_selector_param: RTL and testbench
========================================

Name: column_selector_param

Overview:
- Parametrised successor of the Connect4 column selector. Accepts column drop requests from the game controller and resolves each drop to the lowest free row.
- Maintains occupancy and owner bitmaps for a COLS x ROWS board, per-column fill heights and the turn register.
- Flags invalid drops: out of range, full column or full board.
- Adds a ready/valid-style drop strobe, a bonus-throw mode, a board-full detector and a synchronous new-game clear. Feeds the win checker and display driver.

Parameters:
- COLS, 4, number of board columns (2..8).
- ROWS, 4, number of board rows (2..8).
- COL_W, 2, in_column width; must satisfy 2**COL_W >= COLS.
- IDX_W, 4, cell-index width; must satisfy 2**IDX_W >= COLS*ROWS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous new-game clear, highest priority after reset.
- drop_valid  in  1  one-cycle drop request; only accepted while ready=1.
- in_column  in  COL_W  requested column, 0 = leftmost.
- throw_again  in  1  sampled with drop_valid; 1 = current player keeps the turn after a valid drop.
- ready  out  1  1 in S_IDLE/S_FULL, 0 while a drop is being resolved.
- out_gameboard  out  COLS*ROWS  occupancy bitmap; bit index = row*COLS+col, row 0 = bottom.
- out_players_cells  out  COLS*ROWS  owner bitmap; 1 = player 2; bit is 0 when the cell is empty.
- next_player  out  1  player whose turn it is (0 = P1, 1 = P2).
- drop_done  out  1  one-cycle pulse: valid drop committed.
- invalid_column  out  1  one-cycle pulse: drop rejected.
- last_cell  out  IDX_W  index of the most recently committed cell.
- col_full  out  COLS  per-column full flags.
- board_full  out  1  all cells occupied.

Behaviour:
- Reset (reset=0, async): all bitmaps, heights, last_cell, col_full, board_full, drop_done, invalid_column and next_player = 0. ready = 1, FSM in S_IDLE.
- clear=1: same values as reset, applied at the next edge from any state. Any in-flight drop is discarded with no pulse.
- FSM states: S_IDLE, S_EVAL, S_FULL.
- S_IDLE:
  - drop_valid=1 at edge N latches in_column and throw_again; go to S_EVAL; ready=0 in cycle N+1.
  - drop_valid while ready=0 is ignored, not queued.
- S_EVAL (one cycle), resolving at edge N+1:
  - Invalid if in_column >= COLS or the column height equals ROWS.
  - Invalid: invalid_column=1 for cycle N+2. Board, heights and next_player unchanged.
  - Valid: set the gameboard bit at height[col]*COLS+col. Write the owner bit = next_player. Increment height[col]. last_cell = that index. drop_done=1 for cycle N+2.
  - next_player toggles unless the latched throw_again = 1.
  - Go to S_FULL if the commit fills the last free cell, else S_IDLE.
- Total latency: request edge to pulse = 2 cycles. Pulses are never both high.
- col_full[c] = (height[c] == ROWS); board_full = &col_full. Both are registered and update in the same cycle as drop_done.
- S_FULL: ready=1; every accepted drop pulses invalid_column 2 cycles later with no state change. Leaves only on clear or reset.
- Height counters are ceil(log2(ROWS+1)) bits wide and saturate at ROWS; they never wrap.

Optional Feature:
- Macro: COLUMN_SELECTOR_UNDO_EN.
- When defined:
  - Adds input undo (1 bit) and output undo_done (1 pulse).
  - In S_IDLE or S_FULL, undo=1 with a recorded last move clears cell last_cell, decrements that column's height and restores the pre-move next_player.
  - undo_done pulses 2 cycles later, with the same timing as a drop; the FSM returns to S_IDLE.
  - One level of history only. A second undo, or an undo with no history, pulses invalid_column.
  - drop_valid and undo in the same cycle: the drop wins and the undo is ignored.
  - History is cleared by reset and clear.
- When undefined: no undo port, no history registers; behaviour is exactly as above.

Test Plan:
- Reset: hold reset=0 mid-S_EVAL, then release -> all outputs 0, ready=1, next_player=0, no drop_done pulse.
- Column stack, COLS=ROWS=4: four drops to column 0 -> out_gameboard=16'h1111, out_players_cells=16'h1010, next_player 0→1→0→1→0, col_full=4'b0001. A fifth drop -> invalid_column pulse, bitmaps unchanged.
- Bonus throw: drop column 3 with throw_again=1 as P1 -> bit 3 set, owner bit 3 = 0, next_player stays 0. Next drop with throw_again=0 -> next_player=1.
- Range check, COLS=3, COL_W=2: in_column=3 -> invalid_column pulse 2 cycles after request, board unchanged. A drop_valid during ready=0 produces no pulse.
- Full board: 16 valid drops -> board_full=1 together with the 16th drop_done, FSM in S_FULL. A 17th drop -> invalid_column. Then clear=1 -> all zero, next_player=0.
- COLUMN_SELECTOR_UNDO_EN: drop column 2 as P1, then undo -> bit 2 cleared, next_player=0, undo_done pulse. A second undo -> invalid_column.

Source files
------------

// File: rtl/column_selector_param_if.sv
// Drop-request / board-state bundle between the game controller and column_selector_param.
// With COLUMN_SELECTOR_UNDO_EN defined the bundle also carries undo / undo_done.
interface column_selector_param_if #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COL_W = 2,
    parameter int unsigned IDX_W = 4
) ();
    logic                   clear;
    logic                   drop_valid;
    logic [COL_W-1:0]       in_column;
    logic                   throw_again;
    logic                   ready;
    logic [COLS*ROWS-1:0]   out_gameboard;
    logic [COLS*ROWS-1:0]   out_players_cells;
    logic                   next_player;
    logic                   drop_done;
    logic                   invalid_column;
    logic [IDX_W-1:0]       last_cell;
    logic [COLS-1:0]        col_full;
    logic                   board_full;
`ifdef COLUMN_SELECTOR_UNDO_EN
    logic                   undo;
    logic                   undo_done;

    modport master (
        output clear, drop_valid, in_column, throw_again, undo,
        input  ready, out_gameboard, out_players_cells, next_player, drop_done,
               invalid_column, last_cell, col_full, board_full, undo_done
    );
    modport slave (
        input  clear, drop_valid, in_column, throw_again, undo,
        output ready, out_gameboard, out_players_cells, next_player, drop_done,
               invalid_column, last_cell, col_full, board_full, undo_done
    );
`else
    modport master (
        output clear, drop_valid, in_column, throw_again,
        input  ready, out_gameboard, out_players_cells, next_player, drop_done,
               invalid_column, last_cell, col_full, board_full
    );
    modport slave (
        input  clear, drop_valid, in_column, throw_again,
        output ready, out_gameboard, out_players_cells, next_player, drop_done,
               invalid_column, last_cell, col_full, board_full
    );
`endif
endinterface

// File: rtl/column_selector_param.sv
// Connect4-style column selector: resolves column drops to the lowest free row of a COLS x ROWS
// board. Optional one-level undo is enabled by defining COLUMN_SELECTOR_UNDO_EN.
module column_selector_param #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COL_W = 2,
    parameter int unsigned IDX_W = 4
) (
    input logic                    clk_i,
    input logic                    reset_ni,
    column_selector_param_if.slave bus
);
    localparam int unsigned Cells = COLS * ROWS;
    localparam int unsigned HtW   = $clog2(ROWS + 1);

    typedef enum logic [1:0] {StIdle, StEval, StFull} state_e;

    state_e             state_q, state_d;
    logic [Cells-1:0]   board_q, board_d, owner_q, owner_d;
    logic [HtW-1:0]     height_q [COLS];
    logic [HtW-1:0]     height_d [COLS];
    logic               player_q, player_d;
    logic               done_q, done_d, inv_q, inv_d, pend_q, pend_d;
    logic               throw_q, throw_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [COLS-1:0]    col_full;
    logic               col_ok;
    logic [COL_W-1:0]   col_sel;
    logic [IDX_W-1:0]   cell_idx;
`ifdef COLUMN_SELECTOR_UNDO_EN
    logic               undo_op_q, undo_op_d, hist_q, hist_d, hist_player_q, hist_player_d;
    logic               undo_done_q, undo_done_d;
    logic [COL_W-1:0]   undo_col;

    assign undo_col = COL_W'(int'(last_q) % int'(COLS));
`endif

    always_comb begin
        for (int c = 0; c < int'(COLS); c++) begin
            col_full[c] = (height_q[c] == HtW'(ROWS));
        end
    end

    // Out-of-range columns are steered to column 0 so the height lookup stays in bounds.
    assign col_ok   = int'(col_q) < int'(COLS);
    assign col_sel  = col_ok ? col_q : '0;
    assign cell_idx = IDX_W'(int'(height_q[col_sel]) * int'(COLS) + int'(col_sel));

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        owner_d  = owner_q;
        height_d = height_q;
        player_d = player_q;
        done_d   = 1'b0;
        inv_d    = pend_q;
        pend_d   = 1'b0;
        throw_d  = throw_q;
        col_d    = col_q;
        last_d   = last_q;
`ifdef COLUMN_SELECTOR_UNDO_EN
        undo_op_d     = undo_op_q;
        hist_d        = hist_q;
        hist_player_d = hist_player_q;
        undo_done_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.drop_valid) begin
                    col_d   = bus.in_column;
                    throw_d = bus.throw_again;
                    state_d = StEval;
`ifdef COLUMN_SELECTOR_UNDO_EN
                    undo_op_d = 1'b0;
                end else if (bus.undo) begin
                    undo_op_d = 1'b1;
                    state_d   = StEval;
`endif
                end
            end
            StFull: begin
                // Board is full: drops are answered with a delayed reject, state is frozen.
                if (bus.drop_valid) begin
                    pend_d = 1'b1;
`ifdef COLUMN_SELECTOR_UNDO_EN
                end else if (bus.undo) begin
                    undo_op_d = 1'b1;
                    state_d   = StEval;
`endif
                end
            end
            StEval: begin
`ifdef COLUMN_SELECTOR_UNDO_EN
                if (undo_op_q) begin
                    if (hist_q) begin
                        board_d[last_q]    = 1'b0;
                        owner_d[last_q]    = 1'b0;
                        height_d[undo_col] = height_q[undo_col] - HtW'(1);
                        player_d           = hist_player_q;
                        hist_d             = 1'b0;
                        undo_done_d        = 1'b1;
                    end else begin
                        inv_d = 1'b1;
                    end
                end else begin
`endif
                if (!col_ok || col_full[col_sel]) begin
                    inv_d = 1'b1;
                end else begin
                    board_d[cell_idx] = 1'b1;
                    owner_d[cell_idx] = player_q;
                    height_d[col_sel] = height_q[col_sel] + HtW'(1);
                    last_d            = cell_idx;
                    done_d            = 1'b1;
                    if (!throw_q) player_d = ~player_q;
`ifdef COLUMN_SELECTOR_UNDO_EN
                    hist_d        = 1'b1;
                    hist_player_d = player_q;
`endif
                end
`ifdef COLUMN_SELECTOR_UNDO_EN
                end
`endif
                state_d = (&board_d) ? StFull : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.clear) begin
            state_d  = StIdle;
            board_d  = '0;
            owner_d  = '0;
            height_d = '{default: '0};
            player_d = 1'b0;
            done_d   = 1'b0;
            inv_d    = 1'b0;
            pend_d   = 1'b0;
            last_d   = '0;
`ifdef COLUMN_SELECTOR_UNDO_EN
            hist_d      = 1'b0;
            undo_done_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= StIdle;
            board_q  <= '0;
            owner_q  <= '0;
            height_q <= '{default: '0};
            player_q <= 1'b0;
            done_q   <= 1'b0;
            inv_q    <= 1'b0;
            pend_q   <= 1'b0;
            throw_q  <= 1'b0;
            col_q    <= '0;
            last_q   <= '0;
`ifdef COLUMN_SELECTOR_UNDO_EN
            undo_op_q     <= 1'b0;
            hist_q        <= 1'b0;
            hist_player_q <= 1'b0;
            undo_done_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            owner_q  <= owner_d;
            height_q <= height_d;
            player_q <= player_d;
            done_q   <= done_d;
            inv_q    <= inv_d;
            pend_q   <= pend_d;
            throw_q  <= throw_d;
            col_q    <= col_d;
            last_q   <= last_d;
`ifdef COLUMN_SELECTOR_UNDO_EN
            undo_op_q     <= undo_op_d;
            hist_q        <= hist_d;
            hist_player_q <= hist_player_d;
            undo_done_q   <= undo_done_d;
`endif
        end
    end

    assign bus.ready             = (state_q != StEval);
    assign bus.out_gameboard     = board_q;
    assign bus.out_players_cells = owner_q;
    assign bus.next_player       = player_q;
    assign bus.drop_done         = done_q;
    assign bus.invalid_column    = inv_q;
    assign bus.last_cell         = last_q;
    assign bus.col_full          = col_full;
    assign bus.board_full        = &col_full;
`ifdef COLUMN_SELECTOR_UNDO_EN
    assign bus.undo_done         = undo_done_q;
`endif
endmodule

// File: tb/tb_column_selector_param.sv
// Bench for column_selector_param: a 4x4 instance for directed/table checks and a 3x3 instance
// (COL_W=2, so column 3 is out of range) against a behavioural board model.
module tb_column_selector_param;
    logic clk;
    logic reset_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    column_selector_param_if #(.COLS(4), .ROWS(4), .COL_W(2), .IDX_W(4)) a_if ();
    column_selector_param_if #(.COLS(3), .ROWS(3), .COL_W(2), .IDX_W(4)) b_if ();

    column_selector_param #(.COLS(4), .ROWS(4), .COL_W(2), .IDX_W(4)) dut_a (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (a_if.slave)
    );
    column_selector_param #(.COLS(3), .ROWS(3), .COL_W(2), .IDX_W(4)) dut_b (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the result pulse is visible.
    task automatic drop_a(input logic [1:0] col, input logic thr);
        a_if.drop_valid = 1'b1;
        a_if.in_column = col;
        a_if.throw_again = thr;
        @(negedge clk);
        a_if.drop_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drop_b(input logic [1:0] col, input logic thr);
        b_if.drop_valid = 1'b1;
        b_if.in_column = col;
        b_if.throw_again = thr;
        @(negedge clk);
        b_if.drop_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_a();
        a_if.clear = 1'b1;
        @(negedge clk);
        a_if.clear = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  col;
        logic        thr;
        logic        done;
        logic        inv;
        logic [15:0] board;
        logic [15:0] owner;
        logic        player;
        logic [3:0]  cfull;
        logic [3:0]  last;
    } vec_t;

    vec_t vecs [8];

    // Behavioural model for the 3x3 instance.
    int         h [3];
    logic [8:0] mb, mo;
    logic       mp;

    initial begin
        vecs[0] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 4'b0000, 4'd0};
        vecs[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0010, 1'b0, 4'b0000, 4'd4};
        vecs[2] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'h0111, 16'h0010, 1'b1, 4'b0000, 4'd8};
        vecs[3] = '{2'd0, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h1010, 1'b0, 4'b0001, 4'd12};
        vecs[4] = '{2'd0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h1010, 1'b0, 4'b0001, 4'd12};
        vecs[5] = '{2'd3, 1'b1, 1'b1, 1'b0, 16'h1119, 16'h1010, 1'b0, 4'b0001, 4'd3};
        vecs[6] = '{2'd3, 1'b0, 1'b1, 1'b0, 16'h1199, 16'h1010, 1'b1, 4'b0001, 4'd7};
        vecs[7] = '{2'd1, 1'b0, 1'b1, 1'b0, 16'h119B, 16'h1012, 1'b0, 4'b0001, 4'd1};

        a_if.clear = 0; a_if.drop_valid = 0; a_if.in_column = 0; a_if.throw_again = 0;
        b_if.clear = 0; b_if.drop_valid = 0; b_if.in_column = 0; b_if.throw_again = 0;
`ifdef COLUMN_SELECTOR_UNDO_EN
        a_if.undo = 0; b_if.undo = 0;
`endif
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", a_if.ready, 1);
        check("reset_board", a_if.out_gameboard, 0);
        check("reset_player", a_if.next_player, 0);

        // Reset asserted while a drop is in evaluation.
        a_if.drop_valid = 1'b1; a_if.in_column = 2'd1;
        @(negedge clk);
        a_if.drop_valid = 1'b0;
        check("eval_busy", a_if.ready, 0);
        reset_n = 1'b0;
        #1;
        check("midreset_ready", a_if.ready, 1);
        check("midreset_board", a_if.out_gameboard, 0);
        check("midreset_done", a_if.drop_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("postreset_done", a_if.drop_done, 0);
        check("postreset_board", a_if.out_gameboard, 0);
        check("postreset_last", a_if.last_cell, 0);

        // Column stack and bonus throw table.
        for (int i = 0; i < 8; i++) begin
            drop_a(vecs[i].col, vecs[i].thr);
            check($sformatf("vec%0d_done", i), a_if.drop_done, vecs[i].done);
            check($sformatf("vec%0d_inv", i), a_if.invalid_column, vecs[i].inv);
            check($sformatf("vec%0d_board", i), a_if.out_gameboard, vecs[i].board);
            check($sformatf("vec%0d_owner", i), a_if.out_players_cells, vecs[i].owner);
            check($sformatf("vec%0d_player", i), a_if.next_player, vecs[i].player);
            check($sformatf("vec%0d_cfull", i), a_if.col_full, vecs[i].cfull);
            check($sformatf("vec%0d_last", i), a_if.last_cell, vecs[i].last);
        end

        // A second request while busy must be ignored.
        a_if.drop_valid = 1'b1; a_if.in_column = 2'd2; a_if.throw_again = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_if.drop_valid = 1'b0;
        check("busy_first_done", a_if.drop_done, 1);
        check("busy_board", a_if.out_gameboard, 16'h119F);
        @(negedge clk);
        check("busy_no_second_done", a_if.drop_done, 0);
        check("busy_no_second_inv", a_if.invalid_column, 0);
        check("busy_board_after", a_if.out_gameboard, 16'h119F);
        check("busy_player", a_if.next_player, 1);

        // Fill the whole board, then reject in the full state, then clear.
        clear_a();
        check("clear_board", a_if.out_gameboard, 0);
        check("clear_player", a_if.next_player, 0);
        for (int k = 0; k < 16; k++) begin
            drop_a(2'(k % 4), 1'b0);
            check($sformatf("fill%0d_done", k), a_if.drop_done, 1);
            check($sformatf("fill%0d_bfull", k), a_if.board_full, (k == 15));
        end
        check("full_board", a_if.out_gameboard, 16'hFFFF);
        check("full_owner", a_if.out_players_cells, 16'hAAAA);
        check("full_cfull", a_if.col_full, 4'hF);
        check("full_last", a_if.last_cell, 4'd15);
        check("full_ready", a_if.ready, 1);
        drop_a(2'd1, 1'b0);
        check("full_rej_inv", a_if.invalid_column, 1);
        check("full_rej_done", a_if.drop_done, 0);
        check("full_rej_ready", a_if.ready, 1);
        check("full_rej_board", a_if.out_gameboard, 16'hFFFF);
        clear_a();
        check("clr2_board", a_if.out_gameboard, 0);
        check("clr2_owner", a_if.out_players_cells, 0);
        check("clr2_bfull", a_if.board_full, 0);
        check("clr2_cfull", a_if.col_full, 0);
        check("clr2_inv", a_if.invalid_column, 0);

`ifdef COLUMN_SELECTOR_UNDO_EN
        drop_a(2'd2, 1'b0);
        check("undo_pre_board", a_if.out_gameboard, 16'h0004);
        a_if.undo = 1'b1;
        @(negedge clk);
        a_if.undo = 1'b0;
        @(negedge clk);
        check("undo_done", a_if.undo_done, 1);
        check("undo_board", a_if.out_gameboard, 0);
        check("undo_player", a_if.next_player, 0);
        a_if.undo = 1'b1;
        @(negedge clk);
        a_if.undo = 1'b0;
        @(negedge clk);
        check("undo2_inv", a_if.invalid_column, 1);
        check("undo2_done", a_if.undo_done, 0);
`endif

        // Randomised run on the 3x3 board (column 3 is out of range).
        h = '{0, 0, 0}; mb = '0; mo = '0; mp = 1'b0;
        for (int t = 0; t < 150; t++) begin
            logic [1:0] col;
            logic       thr, valid;
            int         idx;
            if ($urandom_range(0, 39) == 0) begin
                b_if.clear = 1'b1;
                @(negedge clk);
                b_if.clear = 1'b0;
                h = '{0, 0, 0}; mb = '0; mo = '0; mp = 1'b0;
            end
            col = 2'($urandom_range(0, 3));
            thr = ($urandom_range(0, 3) == 0);
            valid = (mb != 9'h1FF) && (col < 2'd3) && (h[col] < 3);
            if (valid) begin
                idx = h[col] * 3 + int'(col);
                mb[idx] = 1'b1;
                mo[idx] = mp;
                h[col]++;
                if (!thr) mp = ~mp;
            end
            drop_b(col, thr);
            check($sformatf("rnd%0d_done", t), b_if.drop_done, valid);
            check($sformatf("rnd%0d_inv", t), b_if.invalid_column, !valid);
            check($sformatf("rnd%0d_board", t), b_if.out_gameboard, mb);
            check($sformatf("rnd%0d_owner", t), b_if.out_players_cells, mo);
            check($sformatf("rnd%0d_player", t), b_if.next_player, mp);
            check($sformatf("rnd%0d_cfull", t), b_if.col_full,
                  {h[2] == 3, h[1] == 3, h[0] == 3});
            check($sformatf("rnd%0d_bfull", t), b_if.board_full, (mb == 9'h1FF));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
